// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Contents:
//   rx_state_t   receiver FSM states (PARITY is only reached when the
//                UART_RX_PARITY_EN build option is defined)
//   OVERSAMPLE   oversample ticks per bit
//   SAMPLE_W     width of the per-bit sample counter
//   MID_SAMPLE   sample index at the middle of the start bit
//   LAST_SAMPLE  sample index at the middle of data/parity/stop bits
//                (counted from the mid-start realignment)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_W    = $clog2(OVERSAMPLE);
    localparam int MID_SAMPLE  = 7;
    localparam int LAST_SAMPLE = 15;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one tick every DIV clocks
//
// Parameters:
//   DIV    clk cycles per oversample tick (>= 1)
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   clear  restart the divider from 0 (used to phase-align to a start edge)
//   tick   one-cycle pulse while the divider sits at DIV-1
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver feeding the rx fifo write port
//
// Build option: UART_RX_PARITY_EN adds an even-parity bit between the data
// bits and the stop bit; without it parity_err is tied low.
//
// Parameters:
//   DATA_BITS    payload bits per frame (>= 2), width of data_out
//   DIV          clk cycles per oversample tick; bit period = 16*DIV clocks
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx           serial line, idles high, asynchronous to clk
//   fifo_full    fifo full flag, sampled at the stop-bit sample
//   wr           one-cycle fifo write strobe
//   data_out     received byte (LSB first on the line), held between strobes
//   busy         high whenever the receiver is not idle
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: good byte dropped because fifo was full
//   parity_err   one-cycle pulse: parity mismatch
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV       = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 fifo_full,
    output logic                 wr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 tick;
    logic                 tick_clear;

    rx_state_t            state;
    rx_state_t            state_next;
    logic [SAMPLE_W-1:0]  sample_cnt;
    logic [SAMPLE_W-1:0]  sample_cnt_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 wr_next;
    logic                 frame_err_next;
    logic                 overrun_err_next;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_bit_next;
    logic                 parity_err_next;
    logic                 parity_err_q;
`endif

    uart_baud_tick #(
        .DIV   (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Two-flop synchroniser plus one more stage for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        sample_cnt_next  = tick ? sample_cnt + 1'b1 : sample_cnt;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift;
        data_next        = data_out;
        wr_next          = 1'b0;
        frame_err_next   = 1'b0;
        overrun_err_next = 1'b0;
        tick_clear       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next     = par_bit;
        parity_err_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Edge-triggered so a held-low (break) line cannot retrigger.
                if (rx_prev && !rx_s) begin
                    tick_clear      = 1'b1;
                    sample_cnt_next = '0;
                    state_next      = START;
                end
            end
            START: begin
                if (tick && sample_cnt == SAMPLE_W'(MID_SAMPLE)) begin
                    if (!rx_s) begin
                        // Realign so that sample 15 falls mid-bit from here on.
                        sample_cnt_next = '0;
                        bit_cnt_next    = '0;
                        state_next      = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == SAMPLE_W'(LAST_SAMPLE)) begin
                    shift_next   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && sample_cnt == SAMPLE_W'(LAST_SAMPLE)) begin
                    par_bit_next = rx_s;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && sample_cnt == SAMPLE_W'(LAST_SAMPLE)) begin
                    state_next = IDLE;
                    if (!rx_s) begin
                        frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shift) != par_bit) begin
                        parity_err_next = 1'b1;
`endif
                    end else if (fifo_full) begin
                        overrun_err_next = 1'b1;
                    end else begin
                        wr_next   = 1'b1;
                        data_next = shift;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data_out    <= '0;
            wr          <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sample_cnt  <= sample_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift       <= shift_next;
            data_out    <= data_next;
            wr          <= wr_next;
            frame_err   <= frame_err_next;
            overrun_err <= overrun_err_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit      <= par_bit_next;
            parity_err_q <= parity_err_next;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int DIV       = 2;
    localparam int BIT_CLKS  = 16 * DIV;

    logic                 clk;
    logic                 reset;
    logic                 rx;
    logic                 fifo_full;
    logic                 wr;
    logic [DATA_BITS-1:0] data_out;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 parity_err;

    uart_rx #(
        .DATA_BITS   (DATA_BITS),
        .DIV         (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .fifo_full   (fifo_full),
        .wr          (wr),
        .data_out    (data_out),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed activity.
    logic [DATA_BITS-1:0] got_q[$];
    int                   wr_cyc_q[$];
    int                   got_fe = 0;
    int                   got_oe = 0;
    int                   got_pe = 0;
    int                   onehot_viol = 0;
    int                   busy_viol = 0;
    int                   hold_viol = 0;
    logic [DATA_BITS-1:0] last_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            if (wr) begin
                got_q.push_back(data_out);
                wr_cyc_q.push_back(cyc);
            end
            if (frame_err)   got_fe++;
            if (overrun_err) got_oe++;
            if (parity_err)  got_pe++;
            if ($countones({wr, frame_err, overrun_err, parity_err}) > 1) onehot_viol++;
            if (wr && busy) busy_viol++;
            if (!wr && data_out !== last_data) hold_viol++;
        end
        last_data = data_out;
    end

    // Expected activity from the frame-level model.
    logic [DATA_BITS-1:0] exp_q[$];
    int                   exp_fe = 0;
    int                   exp_oe = 0;
    int                   exp_pe = 0;
    int                   fall_cyc = 0;

    localparam int OUT_WR = 0;
    localparam int OUT_FE = 1;
    localparam int OUT_PE = 2;
    localparam int OUT_OE = 3;

    function automatic int predict(input logic [DATA_BITS-1:0] d, input logic par,
                                   input logic stp, input logic full);
        int ones;
        ones = 0;
        for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
        if (!stp) return OUT_FE;
`ifdef UART_RX_PARITY_EN
        if (((ones + int'(par)) % 2) != 0) return OUT_PE;
`else
        if (par && ones < 0) return OUT_PE;
`endif
        if (full) return OUT_OE;
        return OUT_WR;
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Sends one frame starting at the next negedge; the line is left at the
    // stop-bit level, then driven high for gap clocks when gap > 0.
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic par,
                              input logic stp, input logic full, input int gap);
        int outcome;
        @(negedge clk);
        fifo_full = full;
        fall_cyc  = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stp);
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        outcome = predict(d, par, stp, full);
        case (outcome)
            OUT_WR:  exp_q.push_back(d);
            OUT_FE:  exp_fe++;
            OUT_PE:  exp_pe++;
            default: exp_oe++;
        endcase
    endtask

    function automatic logic even_par(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    task automatic compare_all(input string tag);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_eq({tag, "_wr_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_data"}, got_q[i], exp_q[i]);
        check_eq({tag, "_frame_err"}, got_fe, exp_fe);
        check_eq({tag, "_overrun_err"}, got_oe, exp_oe);
        check_eq({tag, "_parity_err"}, got_pe, exp_pe);
        check_eq({tag, "_busy_idle"}, busy, 1'b0);
        got_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        got_fe = 0; got_oe = 0; got_pe = 0;
        exp_fe = 0; exp_oe = 0; exp_pe = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        rx        = 1'b1;
        fifo_full = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_wr", wr, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_errs", {frame_err, overrun_err, parity_err}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal frame; wr expected 9.5 bit periods after the falling edge
        // plus 2..3 clocks of synchroniser/edge detect and 1 clock of output register.
        send_frame(8'hA5, even_par(8'hA5), 1'b1, 1'b0, 0);
        lat = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - fall_cyc : -1;
        check_eq("a5_latency_in_window", (lat >= 304 && lat <= 308), 1'b1);
        compare_all("a5");

        // Glitch shorter than half a bit: false start.
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("glitch_busy_high", busy, 1'b1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("glitch_busy_low", busy, 1'b0);
        compare_all("glitch");

        // Framing error, then a break: no retrigger while held low.
        send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b0, 0);
        repeat (3 * BIT_CLKS) @(negedge clk);
        check_eq("break_busy", busy, 1'b0);
        compare_all("frame_err");

        // Overrun, then recovery.
        send_frame(8'h55, even_par(8'h55), 1'b1, 1'b1, 4);
        send_frame(8'h0F, even_par(8'h0F), 1'b1, 1'b0, 0);
        compare_all("overrun");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, even_par(8'h00), 1'b1, 1'b0, 0);
        send_frame(8'hFF, even_par(8'hFF), 1'b1, 1'b0, 0);
        compare_all("b2b");

        // Reset in the middle of the data bits.
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        reset = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_data", data_out, 0);
        check_eq("midrst_wr", wr, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, even_par(8'h81), 1'b1, 1'b0, 0);
        compare_all("midrst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 4);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 4);
        compare_all("parity");
`endif

        // Randomized frames.
        for (int n = 0; n < 12; n++) begin
            logic [DATA_BITS-1:0] d;
            logic                 stp;
            logic                 full;
            logic                 par;
            int                   gap;
            d    = DATA_BITS'($urandom);
            stp  = ($urandom_range(0, 3) != 0);
            full = ($urandom_range(0, 3) == 0);
            par  = even_par(d) ^ ($urandom_range(0, 3) == 0);
            gap  = stp ? $urandom_range(0, 40) : $urandom_range(4, 40);
            send_frame(d, par, stp, full, gap);
        end
        compare_all("random");

        check_eq("onehot_pulses", onehot_viol, 0);
        check_eq("busy_low_at_wr", busy_viol, 0);
        check_eq("data_hold", hold_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Deserialises the asynchronous serial line into bytes and pushes each good byte into the downstream fifo through its write port (wr/data_in).
- Sits directly upstream of the fifo in the UART receive path.
- Uses 16x oversampling, a synchronised rx input, and a start/data/stop state machine.
- Detects framing errors and overrun (a byte arrives while the fifo is full).

Parameters:
- DATA_BITS, 8, payload bits per frame; the data_out width.
- DIV, 27, clk cycles per oversample tick. Bit period = 16*DIV clocks. The default suits 50 MHz / 115200 baud.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- fifo_full  input  1  fifo full flag; when high, the byte is dropped.
- wr  output  1  one-cycle write strobe to the fifo.
- data_out  output  DATA_BITS  received byte, LSB first on the line; valid while wr=1; drives fifo data_in.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun_err  output  1  one-cycle pulse when a good byte is dropped because fifo_full=1.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN.

Behaviour:
- Reset: with reset low, all state returns asynchronously to IDLE.
  - Synchroniser flops and rx_prev reset to 1.
  - Counters reset to 0; data_out resets to 0.
  - wr, busy and all error outputs reset to 0.
  - Reset asserted mid-frame abandons the frame; no wr and no error pulse result.
- Input sync: rx passes through a 2-flop synchroniser to give rx_s; rx_prev is rx_s delayed one clock.
- Tick counter: counts 0..DIV-1 and produces a one-cycle tick at DIV-1. It is cleared to 0 on the start-edge detection in IDLE.
- Sample counter: sample_cnt counts ticks, 4 bits wide, wrapping 15->0.
- IDLE:
  - A falling edge (rx_prev=1 and rx_s=0) clears the tick counter and sample_cnt, then goes to START.
  - A line held low (break) never retriggers, because detection needs the falling edge.
- START: on the tick where sample_cnt==7 (mid start bit):
  - rx_s=0: clear sample_cnt and go to DATA with bit_cnt=0.
  - rx_s=1: false start; return to IDLE with no pulses.
- DATA: on the tick where sample_cnt==15 (mid bit):
  - Shift rx_s into the MSB of the shift register (right-shift) and increment bit_cnt.
  - After DATA_BITS samples, go to STOP (or PARITY when the option is enabled).
- STOP: on the tick where sample_cnt==15:
  - rx_s=0: frame_err pulses in the next cycle; no wr.
  - rx_s=1 and fifo_full=0: wr=1 for one cycle in the next cycle, with data_out equal to the shift register.
  - rx_s=1 and fifo_full=1: overrun_err pulses in the next cycle; no wr.
  - In every case, return to IDLE in the same cycle as the pulse. The receiver is therefore ready from mid stop bit onward.
- Latency: wr rises exactly 1 clk after the stop-sample tick. fifo_full is sampled on that same tick.
- data_out holds its last value between strobes.
- Only one of wr, frame_err, overrun_err and parity_err is ever high in a cycle.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that samples the even-parity bit at sample_cnt==15.
  - On mismatch, parity_err pulses at the stop-sample response time instead of wr. Framing is still checked and frame_err takes priority.
- Undefined: no PARITY state; parity_err is constant 0; the frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Localparams OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15.
- Sub-module uart_baud_tick (parameter DIV; ports clk, reset, clear, tick). It is reusable by the future uart_tx.

Test Plan (DIV=2, so a bit is 32 clk):
- Frame 0xA5 with stop=1, fifo_full=0 -> exactly one wr pulse with data_out=0xA5, about 9.5 bit periods after the falling edge; no error pulses; busy falls with wr.
- rx low for 10 clk then high (glitch shorter than half a bit) -> no wr and no errors; busy returns to 0 after the mid-start sample.
- Frame 0x3C with stop=0 -> one frame_err pulse, no wr; line then held low for 3 bit periods -> no further activity until a new falling edge.
- fifo_full=1 throughout frame 0x55 -> one overrun_err pulse, no wr; the next frame 0x0F with fifo_full=0 -> wr with data_out=0x0F.
- Back-to-back frames 0x00 and 0xFF with no idle gap -> two wr pulses in order, with data_out 0x00 then 0xFF.
- reset pulsed low during DATA of frame 0x81 -> outputs 0 immediately; the next full frame 0x81 -> wr with data_out=0x81.
- UART_RX_PARITY_EN defined:
  - 0xA5 with parity bit 0 -> wr.
  - 0xA5 with parity bit 1 -> parity_err, no wr.
